mem_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared memory bus port of the RV32I core, granting instruction fetch, load/store, debug, and DMA requesters one transaction at a time. Drives the binary select of the Mux41 data/address steering mux in front of memory, issues bus_valid, and tracks completion via bus_ready. Includes a watchdog that aborts a transaction when memory never responds.

---
 rtl/mem_bus_arbiter_pkg.sv | 5 +
 rtl/mem_bus_arbiter_rr_pick.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 101 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// arb_pkg: shared FSM state type and default watchdog length for mem_bus_arbiter.
package arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    localparam int TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker, first set req bit at or after ptr (wrapping).
module rr_pick #(
    parameter int NumReq   = 4,
    parameter int SelWidth = 2
) (
    input  logic [NumReq-1:0]   req,
    input  logic [SelWidth-1:0] ptr,
    output logic [SelWidth-1:0] winner,
    output logic                any_req
);
    logic [SelWidth-1:0] idx;
    // Scan farthest-first so the candidate nearest ptr overwrites the others.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = SelWidth'((int'(ptr) + i) % NumReq);
            if (req[idx]) winner = idx;
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sequencer for the shared memory bus with lock and watchdog abort.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int SelWidth      = 2,
    parameter int TimeoutCycles = TIMEOUT_CYCLES,
    parameter int CntWidth      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumReq-1:0]   req,
    input  logic [NumReq-1:0]   lock,
    input  logic                bus_ready,
    output logic [NumReq-1:0]   gnt,
    output logic [SelWidth-1:0] sel,
    output logic                bus_valid,
    output logic [NumReq-1:0]   done,
    output logic                err,
    output logic [SelWidth-1:0] err_id,
    output logic                busy
);
    arb_state_t          state, state_nx;
    logic [SelWidth-1:0] ptr, ptr_nx, sel_nx, err_id_nx, winner, sel_inc;
    logic [CntWidth-1:0] wdog, wdog_nx;
    logic [NumReq-1:0]   gnt_nx, done_nx;
    logic                err_nx, any_req;

    rr_pick #(.NumReq(NumReq), .SelWidth(SelWidth)) u_pick (
        .req(req),
        .ptr(ptr),
        .winner(winner),
        .any_req(any_req)
    );

    assign sel_inc = (sel == SelWidth'(NumReq - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        wdog_nx   = wdog;
        gnt_nx    = gnt;
        sel_nx    = sel;
        done_nx   = '0;
        err_nx    = 1'b0;
        err_id_nx = err_id;
        if (state == ARB_IDLE) begin
            if (any_req) begin
                state_nx = ARB_BUSY;
                gnt_nx   = NumReq'(1) << winner;
                sel_nx   = winner;
                wdog_nx  = '0;
            end
        end else if (bus_ready) begin
            done_nx = gnt;
            ptr_nx  = sel_inc;
            wdog_nx = '0;
            // A locked owner still asking keeps the bus with no idle bubble.
            if (!(lock[sel] && req[sel])) begin
                state_nx = ARB_IDLE;
                gnt_nx   = '0;
                sel_nx   = '0;
            end
        end else if (wdog == CntWidth'(TimeoutCycles - 1)) begin
            state_nx  = ARB_IDLE;
            gnt_nx    = '0;
            sel_nx    = '0;
            ptr_nx    = sel_inc;
            wdog_nx   = '0;
            err_nx    = 1'b1;
            err_id_nx = sel;
        end else begin
            wdog_nx = wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            ptr    <= '0;
            wdog   <= '0;
            gnt    <= '0;
            sel    <= '0;
            done   <= '0;
            err    <= 1'b0;
            err_id <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            wdog   <= wdog_nx;
            gnt    <= gnt_nx;
            sel    <= sel_nx;
            done   <= done_nx;
            err    <= err_nx;
            err_id <= err_id_nx;
        end
    end

    assign busy      = (state == ARB_BUSY);
    assign bus_valid = busy;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random and directed stimulus against a transaction-level reference model with an event scoreboard.
module tb_mem_bus_arbiter;
    localparam int N = 4, SW = 2, TO = 16, CW = 5;

    logic          clk = 1'b0, rst_n = 1'b0, bus_ready = 1'b0;
    logic [N-1:0]  req = '0, lock = '0;
    logic [N-1:0]  gnt, done;
    logic [SW-1:0] sel, err_id;
    logic          bus_valid, err, busy;

    mem_bus_arbiter #(.NumReq(N), .SelWidth(SW), .TimeoutCycles(TO), .CntWidth(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .bus_ready(bus_ready),
        .gnt(gnt), .sel(sel), .bus_valid(bus_valid), .done(done),
        .err(err), .err_id(err_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; bit is_err; int id;} ev_t;
    ev_t evq[$];
    int total = 0, bad = 0, cyc = 0;
    int owner = -1, ptr = 0, wdog = 0, eid = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        owner = -1; ptr = 0; wdog = 0; eid = 0;
        evq.delete();
    endfunction

    // Reference model: owner index, rotating pointer and a plain cycle count per transaction.
    always @(posedge clk) begin
        int w;
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else if (owner < 0) begin
            w = -1;
            for (int k = 0; k < N && w < 0; k++)
                if (req[(ptr + k) % N]) w = (ptr + k) % N;
            owner = w;
            wdog = 0;
        end else if (bus_ready) begin
            evq.push_back('{cyc, 1'b0, owner});
            ptr = (owner + 1) % N;
            wdog = 0;
            if (!(lock[owner] && req[owner])) owner = -1;
        end else if (wdog == TO - 1) begin
            evq.push_back('{cyc, 1'b1, owner});
            eid = owner;
            ptr = (owner + 1) % N;
            owner = -1;
            wdog = 0;
        end else wdog++;
    end

    // Monitor: per-cycle bus state, plus done/err pulses popped from the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            chk("gnt", int'(gnt), owner >= 0 ? (1 << owner) : 0);
            chk("sel", int'(sel), owner >= 0 ? owner : 0);
            chk("bus_valid", int'(bus_valid), int'(owner >= 0));
            chk("busy", int'(busy), int'(owner >= 0));
            chk("err_id_hold", int'(err_id), eid);
            if (done != '0 || err) begin
                if (evq.size() == 0) chk("unexpected_event", int'(done) + 16 * int'(err), 0);
                else begin
                    e = evq.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("done", int'(done), e.is_err ? 0 : (1 << e.id));
                    chk("err", int'(err), int'(e.is_err));
                    if (e.is_err) chk("err_id", int'(err_id), e.id);
                end
            end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                e = evq.pop_front();
                chk("missed_event", -1, e.id);
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic br, input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            req = r; lock = l; bus_ready = br;
        end
    endtask

    initial begin
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_outs", int'({bus_valid, busy, err, done, sel, err_id}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // single requester
        step(4'b0100, 0, 0, 3);
        step(4'b0100, 0, 1, 1);
        step(0, 0, 0, 3);
        // fairness
        step(4'b1111, 0, 1, 12);
        step(0, 0, 0, 3);
        // lock back-to-back
        step(4'b0011, 4'b0010, 1, 3);
        step(4'b0001, 0, 1, 3);
        step(0, 0, 0, 3);
        // watchdog abort
        step(4'b0010, 0, 0, 19);
        step(0, 0, 0, 2);
        // timeout tie: bus_ready lands exactly on the last watchdog cycle
        step(4'b0010, 0, 0, 16);
        step(4'b0010, 0, 1, 1);
        step(0, 0, 0, 3);
        // reset mid-transaction
        step(4'b1000, 0, 0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_gnt", int'(gnt), 0);
        chk("rst_mid_outs", int'({bus_valid, busy, err, done, sel, err_id}), 0);
        req = 4'b1001;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(4'b1001, 0, 1, 4);
        // random phases: frequent ready, then rare ready to exercise the watchdog
        for (int p = 0; p < 3000; p++)
            step(N'($urandom), N'($urandom), (p / 1000 == 1) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 1), 1);
        step(0, 0, 0, 20);
        chk("queue_empty", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
